// File: rtl/crossbar_pkg.sv
// Shared types for the crossbar scheduler: FSM state encoding, port index type and
// the round-robin pointer advance helper.
package crossbar_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArb,
    StConnect
  } sched_state_e;

  localparam int unsigned DefaultPorts = 8;

  typedef logic [$clog2(DefaultPorts)-1:0] port_idx_t;

  // Pointer value that makes the input after the winner the highest priority next time.
  function automatic int unsigned next_port(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after ptr_i,
// searching upward with wrap from N-1 to 0.
module rr_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic                 valid_o
);

  localparam int unsigned IdxW = $clog2(N);

  logic            found;
  logic [IdxW-1:0] idx;

  // N is a power of two, so the index addition wraps naturally.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = ptr_i + IdxW'(k);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/crossbar_scheduler.sv
// Crossbar connection scheduler: arbitrates per output port, holds granted connections
// for HOLD_CYCLES cycles, then completes them with a one-cycle req_ready pulse.
module crossbar_scheduler
  import crossbar_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [$clog2(N)-1:0] req_dest [N],
  output logic [N-1:0]         req_ready,
  output logic [$clog2(N)-1:0] route [N],
  output logic [N-1:0]         output_enable,
  input  logic                 collision_error,
  output logic                 sched_error,
  output logic                 busy
);

  localparam int unsigned ROUTE_BITS = $clog2(N);
  localparam int unsigned CntW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  sched_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [N-1:0]            oe_q, oe_d;
  logic [N-1:0]            ready_q, ready_d;
  logic [ROUTE_BITS-1:0]   route_q [N];
  logic [ROUTE_BITS-1:0]   route_d [N];
  logic [ROUTE_BITS-1:0]   rr_ptr_q [N];
  logic [ROUTE_BITS-1:0]   rr_ptr_d [N];
  logic                    sched_error_q, sched_error_d;
  logic                    busy_q, busy_d;

  logic [N-1:0] arb_req [N];
  logic [N-1:0] arb_gnt [N];
  logic [N-1:0] arb_valid;
  logic [N-1:0] arb_grant;

  // Row d of arb_req holds the inputs asking for output d.
  always_comb begin
    arb_req = '{default: '0};
    for (int unsigned d = 0; d < N; d++) begin
      for (int unsigned i = 0; i < N; i++) begin
        arb_req[d][i] = req_valid[i] && (req_dest[i] == ROUTE_BITS'(d));
      end
    end
  end

  for (genvar d = 0; d < N; d++) begin : g_arb
    rr_arbiter #(
      .N(N)
    ) u_rr_arbiter (
      .req_i  (arb_req[d]),
      .ptr_i  (rr_ptr_q[d]),
      .gnt_o  (arb_gnt[d]),
      .valid_o(arb_valid[d])
    );
  end

  // Each input targets a single output, so OR-ing the per-output grants stays conflict-free.
  always_comb begin
    arb_grant = '0;
    for (int unsigned d = 0; d < N; d++) begin
      if (arb_valid[d]) begin
        arb_grant = arb_grant | arb_gnt[d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|req_valid) state_d = StArb;
      end
      StArb: begin
        state_d = StConnect;
        cnt_d   = CntW'(HOLD_CYCLES - 1);
      end
      StConnect: begin
        if (collision_error) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so every output leaves a flop.
  always_comb begin
    oe_d          = '0;
    route_d       = '{default: '0};
    ready_d       = '0;
    rr_ptr_d      = rr_ptr_q;
    busy_d        = (state_d != StIdle);
    sched_error_d = sched_error_q | ((state_q == StConnect) && collision_error);
    if (state_d == StConnect) begin
      if (state_q == StArb) begin
        oe_d = arb_grant;
        for (int unsigned i = 0; i < N; i++) begin
          if (arb_grant[i]) route_d[i] = req_dest[i];
        end
      end else begin
        oe_d    = oe_q;
        route_d = route_q;
      end
      if (cnt_d == '0) ready_d = oe_d;
    end
    if ((state_q == StConnect) && !collision_error && (cnt_q == '0)) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (oe_q[i]) rr_ptr_d[route_q[i]] = ROUTE_BITS'(next_port(i, N));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_q          <= '0;
      ready_q       <= '0;
      route_q       <= '{default: '0};
      rr_ptr_q      <= '{default: '0};
      sched_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      oe_q          <= oe_d;
      ready_q       <= ready_d;
      route_q       <= route_d;
      rr_ptr_q      <= rr_ptr_d;
      sched_error_q <= sched_error_d;
      busy_q        <= busy_d;
    end
  end

  assign output_enable = oe_q;
  assign req_ready     = ready_q;
  assign route         = route_q;
  assign sched_error   = sched_error_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_crossbar_scheduler.sv
// Directed bench for crossbar_scheduler with a cycle-step reference model.
module tb_crossbar_scheduler;
  import crossbar_pkg::*;

  localparam int N = 8;
  localparam int H = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  port_idx_t     req_dest [N];
  logic [N-1:0]  req_ready;
  port_idx_t     route [N];
  logic [N-1:0]  output_enable;
  logic          collision_error;
  logic          sched_error;
  logic          busy;

  int checks;
  int errors;

  crossbar_scheduler #(
    .N(N),
    .HOLD_CYCLES(H)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_dest       (req_dest),
    .req_ready      (req_ready),
    .route          (route),
    .output_enable  (output_enable),
    .collision_error(collision_error),
    .sched_error    (sched_error),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: step 0 idle, 1 arbitration, 2..H+1 connection cycles.
  int        m_step;
  logic [N-1:0] m_gnt;
  int        m_dest [N];
  int        m_ptr [N];
  logic      m_err;
  int        m_idx;
  logic      m_found;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_step = 0;
      m_gnt  = '0;
      m_err  = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_ptr[i]  = 0;
        m_dest[i] = 0;
      end
    end else if (m_step == 0) begin
      if (req_valid != '0) m_step = 1;
    end else if (m_step == 1) begin
      m_gnt = '0;
      for (int d = 0; d < N; d++) begin
        m_found = 1'b0;
        for (int k = 0; k < N; k++) begin
          m_idx = (m_ptr[d] + k) % N;
          if (!m_found && req_valid[m_idx] && int'(req_dest[m_idx]) == d) begin
            m_gnt[m_idx]  = 1'b1;
            m_dest[m_idx] = d;
            m_found       = 1'b1;
          end
        end
      end
      m_step = 2;
    end else begin
      if (collision_error) begin
        m_err  = 1'b1;
        m_step = 0;
      end else if (m_step == H + 1) begin
        for (int i = 0; i < N; i++) begin
          if (m_gnt[i]) m_ptr[m_dest[i]] = (i + 1) % N;
        end
        m_step = 0;
      end else begin
        m_step = m_step + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_model();
    logic [N-1:0] e_oe;
    logic [N-1:0] e_rdy;
    e_oe  = (m_step >= 2) ? m_gnt : '0;
    e_rdy = (m_step == H + 1) ? m_gnt : '0;
    chk("model_oe", 32'(output_enable), 32'(e_oe));
    chk("model_ready", 32'(req_ready), 32'(e_rdy));
    chk("model_busy", 32'(busy), 32'(m_step != 0));
    chk("model_err", 32'(sched_error), 32'(m_err));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("model_route%0d", i), 32'(route[i]),
          (m_step >= 2 && m_gnt[i]) ? m_dest[i] : 0);
    end
  endtask

  // One clock: compare against the model mid-cycle, then drop requests that completed.
  task automatic tick();
    logic [N-1:0] seen;
    @(negedge clk);
    cmp_model();
    seen = req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~seen;
  endtask

  task automatic wait_ready(output int idx);
    idx = -1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (req_ready != '0) begin
        for (int i = N - 1; i >= 0; i--) begin
          if (req_ready[i]) idx = i;
        end
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_ready: no req_ready within 40 cycles, got none expected a pulse");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic single_req();
    req_valid[3] = 1'b1;
    req_dest[3]  = 3'd5;
    tick();
    chk("single_busy_c1", 32'(busy), 1);
    chk("single_oe_c1", 32'(output_enable), 0);
    tick();
    chk("single_oe_c2", 32'(output_enable), 32'h08);
    chk("single_route_c2", 32'(route[3]), 5);
    tick();
    tick();
    chk("single_ready_c4", 32'(req_ready), 0);
    tick();
    chk("single_ready_c5", 32'(req_ready), 32'h08);
    chk("single_oe_c5", 32'(output_enable), 32'h08);
    tick();
    chk("single_ready_c6", 32'(req_ready), 0);
    chk("single_oe_c6", 32'(output_enable), 0);
    chk("single_busy_c6", 32'(busy), 0);
    chk("single_ptr5", 32'(dut.rr_ptr_q[5]), 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  int w;

  initial begin
    checks          = 0;
    errors          = 0;
    req_valid       = '0;
    collision_error = 1'b0;
    for (int i = 0; i < N; i++) req_dest[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    tick();
    chk("rst_oe", 32'(output_enable), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(sched_error), 0);
    chk("rst_ptr0", 32'(dut.rr_ptr_q[0]), 0);

    // Single request 3 -> 5
    single_req();

    // Full permutation i -> (i+2)%8
    for (int i = 0; i < N; i++) req_dest[i] = port_idx_t'((i + 2) % N);
    req_valid = '1;
    tick();
    tick();
    chk("perm_oe_c2", 32'(output_enable), 32'hFF);
    chk("perm_route0", 32'(route[0]), 2);
    chk("perm_route7", 32'(route[7]), 1);
    tick();
    tick();
    tick();
    chk("perm_ready_c5", 32'(req_ready), 32'hFF);
    tick();
    chk("perm_ptr0", 32'(dut.rr_ptr_q[0]), 7);

    // Contention on output 0 from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) req_dest[i] = '0;
    req_valid = 8'b0101_0010;
    wait_ready(w);
    chk("cont_first", w, 1);
    wait_ready(w);
    chk("cont_second", w, 4);
    wait_ready(w);
    chk("cont_third", w, 6);
    tick();
    chk("cont_ptr0", 32'(dut.rr_ptr_q[0]), 7);

    // Wrap-around: set pointer of output 2 to 7, then 7 and 0 compete
    req_dest[6]  = 3'd2;
    req_valid[6] = 1'b1;
    wait_ready(w);
    chk("wrap_setup", w, 6);
    tick();
    chk("wrap_ptr2_pre", 32'(dut.rr_ptr_q[2]), 7);
    req_dest[7] = 3'd2;
    req_dest[0] = 3'd2;
    req_valid   = 8'b1000_0001;
    wait_ready(w);
    chk("wrap_first", w, 7);
    tick();
    chk("wrap_ptr2_mid", 32'(dut.rr_ptr_q[2]), 0);
    wait_ready(w);
    chk("wrap_second", w, 0);
    tick();
    chk("wrap_ptr2_end", 32'(dut.rr_ptr_q[2]), 1);

    // Collision abort in cycle 3
    req_dest[2]  = 3'd1;
    req_valid[2] = 1'b1;
    tick();
    tick();
    tick();
    collision_error = 1'b1;
    tick();
    chk("err_flag_c4", 32'(sched_error), 1);
    chk("err_oe_c4", 32'(output_enable), 0);
    chk("err_ready_c4", 32'(req_ready), 0);
    collision_error = 1'b0;
    req_valid       = '0;
    tick();
    chk("err_busy_c5", 32'(busy), 0);
    chk("err_sticky_c5", 32'(sched_error), 1);
    chk("err_ptr1", 32'(dut.rr_ptr_q[1]), 0);

    // Asynchronous reset in the middle of a connection
    req_dest[3]  = 3'd5;
    req_valid[3] = 1'b1;
    tick();
    tick();
    tick();
    chk("arst_oe_before", 32'(output_enable), 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_oe", 32'(output_enable), 0);
    chk("arst_route3", 32'(route[3]), 0);
    chk("arst_ready", 32'(req_ready), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_err", 32'(sched_error), 0);
    chk("arst_ptr0", 32'(dut.rr_ptr_q[0]), 0);
    chk("arst_ptr2", 32'(dut.rr_ptr_q[2]), 0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    single_req();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
